notg_arbiter: RTL
=================

NOTG_ARBITER -- requirements
Module: notg_arbiter

Interface
REQ-001 Parameter: W, 8, data width of each requester operand and of the result.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: req  input  4  per-requester request; bit i = requester i.
REQ-005 Port: din  input  4*W  operands; requester i at bits [i*W +: W].
REQ-006 Port: gnt  output  4  registered one-hot grant; all zero when no grant.
REQ-007 Port: out_ready  input  1  consumer accepts result.
REQ-008 Port: out_valid  output  1  result available.
REQ-009 Port: out_id  output  2  index of the requester that owns the result.
REQ-010 Port: out_data  output  W  bitwise inverse of the granted operand.
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, XFER, RESULT; exactly one state active per cycle.
REQ-013 IDLE, req==0: remain in IDLE.
REQ-014 IDLE, req!=0: select a winner round-robin and go to XFER; gnt = one-hot(winner) for the whole XFER cycle.
REQ-015 Round-robin: search starts at ptr and proceeds ptr, ptr+1, ... modulo 4; the first set bit wins; ptr = winner+1 mod 4 on entry to XFER.
REQ-016 XFER lasts exactly one cycle; din[winner] is captured at the XFER-to-RESULT edge; requester holds din stable while req is high.
REQ-017 RESULT: out_valid=1, out_data=~captured operand, out_id=winner; values stay stable until out_ready=1.
REQ-018 RESULT with out_ready=1: transfer completes at that edge; next state IDLE; out_valid=0 in the following cycle.
REQ-019 req is sampled only in IDLE; req changes in XFER or RESULT have no effect.
REQ-020 Requester deasserts req the cycle after it sees gnt; a still-set req in the next IDLE is a new request.
REQ-021 Latency: req set in IDLE at cycle 0 gives gnt in cycle 1, out_valid in cycle 2; minimum 3 cycles per transfer.
REQ-022 Outside XFER gnt=0; outside RESULT out_valid=0; out_data and out_id hold their last values when out_valid=0.
REQ-023 Simultaneous requests: exactly one grant per transfer; with all 4 held, grants rotate 0,1,2,3,0 from reset.

Reset
REQ-024 rst=1 at an edge: state=IDLE, ptr=0, gnt=0, out_valid=0, out_id=0, out_data=0, busy=0.
REQ-025 Reset during XFER or RESULT abandons the transfer; no out_valid is produced for it.
REQ-026 rst takes priority over every other input in the same cycle.

Configuration
REQ-027 Macro NOTG_ARB_CNT_EN defined: adds output port done_cnt (16 bits); it increments on each completed RESULT handshake, saturates at 16'hFFFF and resets to 0.
REQ-028 Macro NOTG_ARB_CNT_EN undefined: no done_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-029 Single request: W=8, req=4'b0010, din[15:8]=8'hA5, out_ready=1 -> gnt=4'b0010 in cycle 1; out_valid=1, out_id=1, out_data=8'h5A in cycle 2; IDLE in cycle 3.
REQ-030 All requests held, out_ready=1, after reset -> grant sequence 0,1,2,3,0, one grant every 3 cycles.
REQ-031 Backpressure: out_ready=0 for 5 cycles in RESULT -> out_valid, out_id and out_data stable for 5 cycles; completion on the first cycle with out_ready=1.
REQ-032 Mid-operation reset: rst=1 during RESULT -> next cycle out_valid=0, gnt=0, busy=0; the next request goes to requester 0 when ptr scan starts at 0.
REQ-033 Late requests: req changes during XFER or RESULT -> no effect on gnt or out_id for the current transfer.
REQ-034 With NOTG_ARB_CNT_EN: 3 completed transfers -> done_cnt=3; counter preset near 16'hFFFF saturates at 16'hFFFF.

Source files
------------

// File: rtl/notg_arbiter.sv
// rtl/notg_arbiter.sv - 4-way round-robin arbiter returning the inverted granted operand (optional NOTG_ARB_CNT_EN adds done_cnt)
module notg_arbiter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] din,
    output logic [3:0]     gnt,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [1:0]     out_id,
    output logic           busy,
    output logic [W-1:0]   out_data
`ifdef NOTG_ARB_CNT_EN
    ,
    output logic [15:0]    done_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t         r_state;
    logic [1:0]     r_ptr;
    logic [1:0]     r_win;
    logic [3:0]     r_gnt;
    logic           r_out_valid;
    logic [1:0]     r_out_id;
    logic [W-1:0]   r_out_data;

    logic           w_found;
    logic [1:0]     w_win;
    logic [1:0]     w_idx;
    logic [W-1:0]   w_operand;

    // Round-robin scan starting at the pointer; the first requester found wins
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_operand = din[int'(r_win)*W +: W];

    // Transfer FSM: IDLE samples requests, XFER shows the grant for one cycle, RESULT holds until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd0;
            r_win       <= 2'd0;
            r_gnt       <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_id    <= 2'd0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= XFER;
                        r_win   <= w_win;
                        r_ptr   <= w_win + 2'd1;
                        r_gnt   <= 4'b0001 << w_win;
                    end
                end
                XFER: begin
                    r_state     <= RESULT;
                    r_gnt       <= 4'd0;
                    r_out_valid <= 1'b1;
                    r_out_id    <= r_win;
                    r_out_data  <= ~w_operand;
                end
                RESULT: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt       <= 4'd0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef NOTG_ARB_CNT_EN
    logic [15:0] r_done_cnt;

    // Count accepted results, sticking at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_cnt <= 16'd0;
        end else if (r_state == RESULT && out_ready && r_done_cnt != 16'hFFFF) begin
            r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

    assign done_cnt = r_done_cnt;
`endif

    assign gnt       = r_gnt;
    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_data  = r_out_data;
    assign busy      = (r_state != IDLE);

endmodule
